// File: rtl/prog_ctr_pkg.sv
// rtl/prog_ctr_pkg.sv - shared types, entry table and entry lookup for prog_ctr_seq
package prog_ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2,
        BR_GE = 2'd3
    } brcond_e;

    localparam int unsigned NUM_ENTRIES = 4;
    localparam int unsigned PROG_ENTRY [NUM_ENTRIES] = '{4, 64, 128, 192};

    // Out-of-range selections fall back to entry 0
    function automatic int unsigned entry_addr(input int unsigned sel, input int unsigned num_progs);
        if (sel < num_progs && sel < NUM_ENTRIES) begin
            return PROG_ENTRY[sel[1:0]];
        end
        return PROG_ENTRY[0];
    endfunction

endpackage

// File: rtl/prog_ctr_seq_if.sv
// rtl/prog_ctr_seq_if.sv - decoder/ALU control strobes in, fetch address and status out
interface prog_ctr_seq_if #(
    parameter int PC_W  = 10,
    parameter int SEL_W = 2
);
    logic             start;
    logic [SEL_W-1:0] prog_sel;
    logic             jump;
    logic             branch;
    logic [1:0]       br_cond;
    logic             is_equal;
    logic             is_less;
    logic             call;
    logic             ret;
    logic             halt;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  prog_ctr;
    logic             running;
    logic             done;
    logic             stack_err;

    modport master (
        output start, prog_sel, jump, branch, br_cond, is_equal, is_less,
               call, ret, halt, target,
        input  prog_ctr, running, done, stack_err
    );

    modport slave (
        input  start, prog_sel, jump, branch, br_cond, is_equal, is_less,
               call, ret, halt, target,
        output prog_ctr, running, done, stack_err
    );
endinterface

// File: rtl/prog_ctr_seq_ret_stack.sv
// rtl/prog_ctr_seq_ret_stack.sv - return-address LIFO; overflowing push and underflowing pop are dropped
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] top_idx;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign top_idx = cnt_q - CNT_W'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx[IDX_W-1:0]];

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)      cnt_d = '0;
        else if (do_pop)  cnt_d = cnt_q - CNT_W'(1);
        else if (do_push) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Entries need no reset: the count alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (do_push && !do_pop) mem_q[cnt_q[IDX_W-1:0]] <= data_i;
    end
endmodule

// File: rtl/prog_ctr_seq.sv
// rtl/prog_ctr_seq.sv - fetch-stage program counter with launch sequencing, branches and call/return stack
module prog_ctr_seq
    import prog_ctr_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int NUM_PROGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    prog_ctr_seq_if.slave bus
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              err_q, err_d;
    logic              running_q, done_q;
    logic              push, pop, clr;
    logic              taken;
    logic [PC_W-1:0]   stk_top;
    logic              stk_full, stk_empty;

    ret_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clr),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        taken = 1'b0;
        case (brcond_e'(bus.br_cond))
            BR_EQ: taken = bus.is_equal;
            BR_NE: taken = !bus.is_equal;
            BR_LT: taken = bus.is_less;
            BR_GE: taken = !bus.is_less;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sel_d   = sel_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (bus.start) begin
                    state_d = ST_ARMED;
                    sel_d   = bus.prog_sel;
                end
            end
            ST_ARMED: begin
                if (bus.start) begin
                    sel_d = bus.prog_sel;
                end else begin
                    pc_d    = PC_W'(entry_addr(32'(sel_q), NUM_PROGS));
                    clr     = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Strobes are mutually prioritised; only one acts per cycle
                if (bus.start) begin
                    state_d = ST_ARMED;
                    sel_d   = bus.prog_sel;
                end else if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (bus.ret) begin
                    if (!stk_empty) begin
                        pc_d = stk_top;
                        pop  = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (bus.call) begin
                    if (!stk_full) begin
                        pc_d = bus.target;
                        push = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (bus.jump) begin
                    pc_d = bus.target;
                end else if (bus.branch && taken) begin
                    pc_d = pc_q + bus.target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_HALTED);
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_prog_ctr_seq.sv
// tb/tb_prog_ctr_seq.sv - directed and randomized checks of prog_ctr_seq against a queue-based reference model
module tb_prog_ctr_seq;
    localparam int PC_W = 10;
    localparam int NP   = 4;
    localparam int SD   = 2;
    localparam int MASK = (1 << PC_W) - 1;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_HALTED = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_ctr_seq_if #(.PC_W(PC_W), .SEL_W(2)) bus ();
    prog_ctr_seq #(.PC_W(PC_W), .NUM_PROGS(NP), .STACK_DEPTH(SD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_mode, m_pc, m_sel, m_err;
    int m_stack[$];
    int entries[4] = '{4, 64, 128, 192};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 0; m_sel = 0; m_err = 0;
        m_stack.delete();
    endtask

    function automatic int signed_tgt(input int t);
        return (t >= (1 << (PC_W - 1))) ? t - (1 << PC_W) : t;
    endfunction

    task automatic model_step();
        bit tk;
        if (m_mode == M_IDLE || m_mode == M_HALTED) begin
            if (bus.start) begin m_mode = M_ARMED; m_sel = int'(bus.prog_sel); end
        end else if (m_mode == M_ARMED) begin
            if (bus.start) m_sel = int'(bus.prog_sel);
            else begin
                m_pc = entries[(m_sel < NP) ? m_sel : 0];
                m_stack.delete(); m_err = 0; m_mode = M_RUN;
            end
        end else begin
            if (bus.start) begin m_mode = M_ARMED; m_sel = int'(bus.prog_sel); end
            else if (bus.halt) m_mode = M_HALTED;
            else if (bus.ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_pc = (m_pc + 1) & MASK; m_err = 1; end
            end else if (bus.call) begin
                if (m_stack.size() < SD) begin
                    m_stack.push_back((m_pc + 1) & MASK);
                    m_pc = int'(bus.target);
                end else begin m_pc = (m_pc + 1) & MASK; m_err = 1; end
            end else if (bus.jump) m_pc = int'(bus.target);
            else if (bus.branch) begin
                case (bus.br_cond)
                    2'd0: tk = bus.is_equal;
                    2'd1: tk = !bus.is_equal;
                    2'd2: tk = bus.is_less;
                    default: tk = !bus.is_less;
                endcase
                m_pc = tk ? (m_pc + signed_tgt(int'(bus.target))) & MASK : (m_pc + 1) & MASK;
            end else m_pc = (m_pc + 1) & MASK;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pc", 32'(bus.prog_ctr), 32'(m_pc));
        check("running", 32'(bus.running), 32'(m_mode == M_RUN));
        check("done", 32'(bus.done), 32'(m_mode == M_HALTED));
        check("stack_err", 32'(bus.stack_err), 32'(m_err));
    endtask

    task automatic quiet();
        bus.start = 0; bus.jump = 0; bus.branch = 0; bus.call = 0; bus.ret = 0; bus.halt = 0;
        bus.br_cond = 0; bus.is_equal = 0; bus.is_less = 0; bus.target = 0;
    endtask

    task automatic launch(input int sel);
        quiet(); bus.start = 1; bus.prog_sel = 2'(sel); tick(); tick();
        quiet(); tick();
    endtask

    initial begin
        quiet();
        bus.prog_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(bus.prog_ctr), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.stack_err), 0);
        rst_n = 1;

        bus.start = 1; bus.prog_sel = 0; tick();
        check("armed_hold", 32'(bus.prog_ctr), 0);
        tick();
        quiet(); tick();
        check("entry0", 32'(bus.prog_ctr), 4);
        check("entry_running", 32'(bus.running), 1);
        tick();
        check("inc", 32'(bus.prog_ctr), 5);

        bus.jump = 1; bus.target = 10; tick(); quiet();
        check("jump", 32'(bus.prog_ctr), 10);
        bus.branch = 1; bus.br_cond = 0; bus.is_equal = 1; bus.target = 10; tick();
        check("br_eq", 32'(bus.prog_ctr), 20);
        bus.br_cond = 1; tick();
        check("br_ne_not", 32'(bus.prog_ctr), 21);
        bus.br_cond = 2; bus.is_less = 1; bus.target = PC_W'(-6); tick(); quiet();
        check("br_lt_back", 32'(bus.prog_ctr), 15);

        bus.call = 1; bus.target = 100; tick();
        check("call1", 32'(bus.prog_ctr), 100);
        bus.target = 200; tick();
        check("call2", 32'(bus.prog_ctr), 200);
        bus.target = 300; tick(); quiet();
        check("call_ovf", 32'(bus.prog_ctr), 201);
        check("call_ovf_err", 32'(bus.stack_err), 1);
        bus.ret = 1; bus.call = 1; tick();
        check("ret1_wins", 32'(bus.prog_ctr), 101);
        bus.call = 0; tick(); quiet();
        check("ret2", 32'(bus.prog_ctr), 16);

        launch(1);
        check("entry1", 32'(bus.prog_ctr), 64);
        check("err_cleared", 32'(bus.stack_err), 0);
        bus.jump = 1; bus.target = 7; tick(); quiet();
        bus.ret = 1; tick(); quiet();
        check("ret_empty", 32'(bus.prog_ctr), 8);
        check("ret_empty_err", 32'(bus.stack_err), 1);
        tick();
        check("err_sticky", 32'(bus.stack_err), 1);

        bus.jump = 1; bus.target = 1023; tick(); quiet();
        tick();
        check("wrap_inc", 32'(bus.prog_ctr), 0);
        tick();
        bus.branch = 1; bus.br_cond = 3; bus.is_less = 0; bus.target = PC_W'(-2); tick(); quiet();
        check("wrap_br", 32'(bus.prog_ctr), 1023);

        bus.jump = 1; bus.target = 40; tick(); quiet();
        bus.halt = 1; bus.call = 1; tick(); quiet();
        check("halt_done", 32'(bus.done), 1);
        check("halt_pc", 32'(bus.prog_ctr), 40);
        bus.jump = 1; bus.target = 5; tick(); quiet();
        check("halt_ignores", 32'(bus.prog_ctr), 40);
        launch(2);
        check("entry2", 32'(bus.prog_ctr), 128);

        for (int i = 0; i < 600; i++) begin
            bus.start    = ($urandom_range(15) == 0);
            bus.prog_sel = 2'($urandom);
            bus.halt     = ($urandom_range(31) == 0);
            bus.ret      = ($urandom_range(5) == 0);
            bus.call     = ($urandom_range(5) == 0);
            bus.jump     = ($urandom_range(7) == 0);
            bus.branch   = ($urandom_range(3) == 0);
            bus.br_cond  = 2'($urandom);
            bus.is_equal = 1'($urandom);
            bus.is_less  = 1'($urandom);
            bus.target   = PC_W'($urandom);
            tick();
        end

        launch(3);
        bus.call = 1; bus.target = 300; tick(); quiet();
        tick();
        rst_n = 0;
        #1;
        model_reset();
        check("midrst_pc", 32'(bus.prog_ctr), 0);
        check("midrst_running", 32'(bus.running), 0);
        check("midrst_err", 32'(bus.stack_err), 0);
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        launch(0);
        bus.ret = 1; tick(); quiet();
        check("post_rst_stack_empty", 32'(bus.stack_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_ctr_seq.md
# prog_ctr_seq

Parametrised program counter with start/arm sequencing, multiple program entry points, conditional PC-relative branches, absolute jumps, and a hardware call/return stack. Sits in the fetch stage: drives the instruction-memory address, takes control strobes from the decoder and condition flags from the ALU.

## Interface
- PC_W, 10, program counter width in bits
- NUM_PROGS, 4, number of selectable program entry points, from `PROG_ENTRY` in the package
- STACK_DEPTH, 4, return-address stack entries, ≥1

- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- Start  in  1  arm/launch request
- ProgSel  in  $clog2(NUM_PROGS)  program index, sampled while Start=1
- Jump  in  1  absolute jump to Target
- Branch  in  1  conditional PC-relative branch
- BrCond  in  2  branch condition: EQ, NE, LT, GE
- IsEqual  in  1  ALU equal flag
- IsLess  in  1  ALU signed-less flag
- Call  in  1  push PC+1, jump to Target
- Ret  in  1  pop return address into PC
- Halt  in  1  stop execution
- Target  in  PC_W  absolute address for Jump/Call; signed two's-complement offset for Branch
- ProgCtr  out  PC_W  current PC
- Running  out  1  high in RUN
- Done  out  1  high in HALTED
- StackErr  out  1  sticky: overflow on Call or underflow on Ret

## Operation
- States: IDLE, ARMED, RUN, HALTED.
- IDLE: PC held. Start=1 -> ARMED, latch ProgSel.
- ARMED: PC held, ProgSel re-latched every cycle while Start=1. Start=0 -> PC <= PROG_ENTRY[sel], stack cleared, StackErr cleared, -> RUN.
- RUN, one action per cycle, priority Start > Halt > Ret > Call > Jump > Branch > increment:
  - Start=1: abort -> ARMED, PC held.
  - Halt: -> HALTED, PC held.
  - Ret: stack non-empty: PC <= top, pop. Empty: PC <= PC+1, StackErr <= 1.
  - Call: stack not full: push PC+1, PC <= Target. Full: PC <= PC+1, StackErr <= 1, no push.
  - Jump: PC <= Target.
  - Branch taken (EQ: IsEqual; NE: !IsEqual; LT: IsLess; GE: !IsLess): PC <= PC + signed Target. Not taken: PC+1.
  - Otherwise PC <= PC+1.
- HALTED: Done=1, PC held. Start=1 -> ARMED.
- Arithmetic: all PC updates modulo 2^PC_W. PC = 2^PC_W−1 increments to 0. Relative branches wrap in both directions. Pushed PC+1 wraps the same way.
- ProgSel ≥ NUM_PROGS selects entry 0.
- Strobes outside RUN are ignored.

## Timing
- Reset asserted, asynchronously: state IDLE, ProgCtr=0, stack empty, Running=0, Done=0, StackErr=0. Reset mid-RUN discards the stack immediately.
- Every PC update takes effect on the rising edge after the strobe is sampled. One-cycle latency, no stalls.
- Launch: Start sampled high for ≥1 edge. The edge where Start is first seen low loads the entry. The first entry instruction is therefore on ProgCtr one cycle after Start falls.
- Running and Done are registered state decodes, valid in the same cycle as the state.
- Call and Ret in the same cycle: Ret wins, Call is dropped with no push.

## Structure
- Package prog_ctr_pkg: `state_e`, `brcond_e` (EQ=0, NE=1, LT=2, GE=3), and `PROG_ENTRY` constant array (entry 0 = 4, 1 = 64, 2 = 128, 3 = 192).
- One sub-module, ret_stack: a parametrised LIFO (width PC_W, depth STACK_DEPTH).
  - Inputs: push, pop, clear, data.
  - Outputs: top, full, empty.
  - Push when full and pop when empty are ignored internally.

## Test plan
- Reset low, then Start high for 2 cycles with ProgSel=0, then low: ProgCtr holds 0 through arming, then 4, 5 on subsequent edges; Running=1.
- At PC=5: Jump with Target=10 -> 10. Branch EQ with IsEqual=1, Target=10 -> 20. Branch NE with IsEqual=1 -> 21. Branch LT with IsLess=1, Target=−6 -> 15.
- At PC=15, STACK_DEPTH=2: Call Target=100 -> 100; Call Target=200 -> 200; third Call Target=300 -> 201 with StackErr=1; Ret -> 101; Ret -> 16.
- Ret with empty stack at PC=7 -> 8 with StackErr=1. StackErr stays 1 until the next launch.
- PC_W=10, Jump Target=1023, then an increment -> 0. Branch Target=−2 from PC=1 -> 1023.
- Halt at PC=40 -> Done=1, PC holds 40. Start with ProgSel=2, then Start low -> PC=128. Reset asserted mid-run -> ProgCtr=0 immediately, state IDLE.
